everloop_seq: RTL and testbench
===============================

EVERLOOP_SEQ -- requirements
Module: everloop_seq

Interface
REQ-001 The block SHALL have parameter N_LEDS, default 35, number of LEDs on the ring (4 bytes each, RGBW).
REQ-002 The block SHALL have parameter TICK_DIV, default 1000000, clk cycles per animation step (minimum 16).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  sole clock, all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port host_req  input  1  host byte-write request, held until granted.
REQ-006 The block SHALL have port host_adr  input  11  host byte address in LED RAM.
REQ-007 The block SHALL have port host_dat  input  8  host write byte.
REQ-008 The block SHALL have port host_gnt  output  1  one-cycle pulse, host byte written this cycle.
REQ-009 The block SHALL have port anim_en  input  1  enables the rotating-LED animation.
REQ-010 The block SHALL have port anim_dir  input  1  0 = increment position, 1 = decrement.
REQ-011 The block SHALL have port anim_color  input  32  lit-LED colour; byte k goes to address 4*pos+k.
REQ-012 The block SHALL have port ram_we  output  1  LED RAM write strobe (also drives RAM enable).
REQ-013 The block SHALL have port ram_adr  output  11  LED RAM write address.
REQ-014 The block SHALL have port ram_dat  output  8  LED RAM write data.
REQ-015 The block SHALL have port busy  output  1  high while an animation burst is in progress.
REQ-016 The block SHALL have port pos  output  6  current lit-LED index, 0..N_LEDS-1.

Function
REQ-017 The FSM SHALL have states IDLE, HOST, CLR and SET; CLR and SET each last exactly 4 cycles (byte k = 0..3).
REQ-018 The tick counter SHALL count 0..TICK_DIV-1 while anim_en=1, wrap to 0 and raise tick_pend at wrap; it SHALL hold at 0 while anim_en=0.
REQ-019 From IDLE, host_req=1 SHALL take priority: move to HOST; in HOST, ram_we=1, ram_adr=host_adr, ram_dat=host_dat and host_gnt=1 for one cycle; then return to IDLE (one host byte per grant).
REQ-020 From IDLE with host_req=0 and tick_pend=1, the FSM SHALL clear tick_pend, go to CLR, write the CLR value to 4*pos+k, compute the new pos, then go to SET and write anim_color byte k to 4*newpos+k.
REQ-021 pos SHALL update on the last CLR cycle: dir=0 gives N_LEDS-1 -> 0 wrap, dir=1 gives 0 -> N_LEDS-1 wrap; anim_dir is sampled at that cycle only.
REQ-022 A CLR+SET burst SHALL be atomic: host_req arriving mid-burst waits and is granted in the cycle after the last SET cycle.
REQ-023 A tick arriving while the FSM is not in IDLE SHALL remain pending (one level, no count); further ticks before service SHALL be dropped.
REQ-024 anim_en falling mid-burst SHALL let the burst complete and SHALL clear tick_pend.
REQ-025 busy SHALL be 1 in CLR and SET and 0 otherwise; ram_we SHALL be 0 in IDLE.
REQ-026 Address arithmetic SHALL be 11-bit unsigned: ram_adr = {pos,2'b00}+k.

Reset
REQ-027 Reset SHALL force: state IDLE, tick counter 0, tick_pend 0, pos 0, host_gnt 0, ram_we 0, ram_adr 0, ram_dat 0, busy 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst, with all outputs at reset values on the following cycle.

Configuration
REQ-029 Macro EVERLOOP_SEQ_TRAIL_EN defined: the CLR value SHALL be anim_color byte k shifted right by 1 (half-brightness trail).
REQ-030 Macro EVERLOOP_SEQ_TRAIL_EN undefined: the CLR value SHALL be 8'h00.

Verification
REQ-031 TICK_DIV=16, anim_en=1, colour 0x11223344, pos=0 -> after 16 cycles, writes 0x00 to adr 0..3, then 0x44,0x33,0x22,0x11 to adr 4..7; pos=1.
REQ-032 pos=34, dir=0, one tick -> CLR on adr 136..139, SET on adr 0..3, pos=0; with dir=1 from pos=0 -> SET on adr 136..139, pos=34.
REQ-033 host_req adr=0x123 dat=0xA5 raised during SET k=1 -> no grant until burst ends; then host_gnt=1, ram_adr=0x123, ram_dat=0xA5 in the first cycle after the last SET cycle.
REQ-034 host_req and tick_pend both set in IDLE -> host byte written first, CLR starts the next cycle; two ticks during a long host stream -> exactly one burst.
REQ-035 Reset asserted during CLR k=2 -> next cycle ram_we=0, pos=0, busy=0; no further RAM writes until the next tick.
REQ-036 EVERLOOP_SEQ_TRAIL_EN defined, colour 0x80402010 -> CLR bytes 0x08,0x10,0x20,0x40.

Source files
------------

// File: rtl/everloop_seq.sv
// ---------------------------------------------------------------------------
// everloop_seq
// Sequencer for an RGBW LED ring RAM (4 bytes per LED). It arbitrates between
// single-byte host writes and a rotating "lit LED" animation. Every animation
// tick runs an atomic 8-cycle burst: 4 CLR writes at the old position, then
// 4 SET writes of anim_color at the new position.
//
// Optional feature: define EVERLOOP_SEQ_TRAIL_EN so that the CLR bytes become
// half of the colour bytes (a dim trail). Without it, the CLR bytes are 8'h00.
//
// Ports
//   clk         in   sole clock, rising edge
//   reset       in   synchronous active-high reset
//   host_req    in   host byte-write request, held until granted
//   host_adr    in   [10:0] host byte address
//   host_dat    in   [7:0]  host byte
//   host_gnt    out  one-cycle pulse when the host byte is written
//   anim_en     in   enable the animation tick counter
//   anim_dir    in   0 = step up, 1 = step down (sampled on the last CLR cycle)
//   anim_color  in   [31:0] lit colour, byte k goes to address 4*pos+k
//   ram_we      out  RAM write strobe / enable
//   ram_adr     out  [10:0] RAM write address
//   ram_dat     out  [7:0]  RAM write data
//   busy        out  high during a CLR+SET burst
//   pos         out  [5:0] current lit LED index
// ---------------------------------------------------------------------------
module everloop_seq #(
    parameter int N_LEDS   = 35,
    parameter int TICK_DIV = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_req,
    input  logic [10:0] host_adr,
    input  logic [7:0]  host_dat,
    output logic        host_gnt,
    input  logic        anim_en,
    input  logic        anim_dir,
    input  logic [31:0] anim_color,
    output logic        ram_we,
    output logic [10:0] ram_adr,
    output logic [7:0]  ram_dat,
    output logic        busy,
    output logic [5:0]  pos
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOST = 2'd1,
        CLR  = 2'd2,
        SET  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_k;
    logic [1:0]       w_k_nxt;
    logic [5:0]       r_pos;
    logic [5:0]       w_pos_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick_pend;
    logic             w_wrap;
    logic             w_consume;
    logic [7:0]       w_col_byte;
    logic [7:0]       w_clr_byte;
    logic [10:0]      w_led_adr;

    function automatic logic [7:0] clr_value(input logic [7:0] col);
`ifdef EVERLOOP_SEQ_TRAIL_EN
        return {1'b0, col[7:1]};
`else
        return col & 8'h00;
`endif
    endfunction

    function automatic logic [5:0] next_pos(input logic [5:0] p, input logic dir);
        if (!dir) begin
            return (p == 6'(N_LEDS - 1)) ? 6'd0 : p + 6'd1;
        end else begin
            return (p == 6'd0) ? 6'(N_LEDS - 1) : p - 6'd1;
        end
    endfunction

    assign w_wrap     = anim_en && (r_cnt == CNT_W'(TICK_DIV - 1));
    assign w_col_byte = anim_color[{r_k, 3'b000} +: 8];
    assign w_clr_byte = clr_value(w_col_byte);
    assign w_led_adr  = {3'b000, r_pos, 2'b00} + {9'd0, r_k};
    assign pos        = r_pos;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_pos_nxt   = r_pos;
        w_consume   = 1'b0;
        host_gnt    = 1'b0;
        ram_we      = 1'b0;
        ram_adr     = 11'd0;
        ram_dat     = 8'd0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (host_req) begin
                    w_state_nxt = HOST;
                end else if (r_tick_pend) begin
                    w_state_nxt = CLR;
                    w_k_nxt     = 2'd0;
                    w_consume   = 1'b1;
                end
            end
            HOST: begin
                host_gnt = 1'b1;
                ram_we   = 1'b1;
                ram_adr  = host_adr;
                ram_dat  = host_dat;
                // One byte per grant: a still-high host_req is not re-served
                // here, so a pending tick gets the next slot.
                if (r_tick_pend) begin
                    w_state_nxt = CLR;
                    w_k_nxt     = 2'd0;
                    w_consume   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CLR: begin
                busy    = 1'b1;
                ram_we  = 1'b1;
                ram_adr = w_led_adr;
                ram_dat = w_clr_byte;
                w_k_nxt = r_k + 2'd1;
                if (r_k == 2'd3) begin
                    w_state_nxt = SET;
                    w_pos_nxt   = next_pos(r_pos, anim_dir);
                end
            end
            SET: begin
                busy    = 1'b1;
                ram_we  = 1'b1;
                ram_adr = w_led_adr;
                ram_dat = w_col_byte;
                w_k_nxt = r_k + 2'd1;
                // Leave the burst straight into the next job so a waiting
                // host is granted in the very next cycle.
                if (r_k == 2'd3) begin
                    if (host_req) begin
                        w_state_nxt = HOST;
                    end else if (r_tick_pend) begin
                        w_state_nxt = CLR;
                        w_consume   = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_k         <= 2'd0;
            r_pos       <= 6'd0;
            r_cnt       <= '0;
            r_tick_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_pos   <= w_pos_nxt;
            if (!anim_en || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Single-level pending flag: extra ticks collapse into one; a new
            // wrap wins over a same-cycle consume.
            if (w_wrap) begin
                r_tick_pend <= 1'b1;
            end else if (!anim_en || w_consume) begin
                r_tick_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_everloop_seq.sv
module tb_everloop_seq;
    localparam int N_LEDS   = 35;
    localparam int TICK_DIV = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_req;
    logic [10:0] host_adr;
    logic [7:0]  host_dat;
    logic        host_gnt;
    logic        anim_en;
    logic        anim_dir;
    logic [31:0] anim_color;
    logic        ram_we;
    logic [10:0] ram_adr;
    logic [7:0]  ram_dat;
    logic        busy;
    logic [5:0]  pos;

    typedef struct {
        logic [10:0] adr;
        logic [7:0]  dat;
    } wr_t;

    wr_t burst_q[$];
    wr_t host_q[$];
    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  m_pos    = 0;

    everloop_seq #(.N_LEDS(N_LEDS), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_adr(host_adr), .host_dat(host_dat), .host_gnt(host_gnt),
        .anim_en(anim_en), .anim_dir(anim_dir), .anim_color(anim_color),
        .ram_we(ram_we), .ram_adr(ram_adr), .ram_dat(ram_dat),
        .busy(busy), .pos(pos)
    );

    always #5 clk = ~clk;

    // Write log, sampled on the falling edge
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (host_gnt === 1'b1) host_q.push_back('{ram_adr, ram_dat});
            else burst_q.push_back('{ram_adr, ram_dat});
        end
    end

    // Reference: value written over the old LED
    function automatic logic [7:0] clr_model(input logic [31:0] color, input int k);
`ifdef EVERLOOP_SEQ_TRAIL_EN
        return 8'(color >> (8 * k)) >> 1;
`else
        return 8'h00;
`endif
    endfunction

    // Reference: one tick = clear 4 bytes of the old LED, step, light new LED
    task automatic model_burst(input logic [31:0] color, input logic dir);
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back('{11'(4 * m_pos + k), clr_model(color, k)});
        m_pos = dir ? (m_pos + N_LEDS - 1) % N_LEDS : (m_pos + 1) % N_LEDS;
        for (int k = 0; k < 4; k++) exp_q.push_back('{11'(4 * m_pos + k), 8'(color >> (8 * k))});
    endtask

    task automatic clear_logs();
        burst_q.delete();
        host_q.delete();
    endtask

    // Enable animation until one burst has run, then disable it
    task automatic run_one_tick(input logic [31:0] color, input logic dir);
        int n;
        anim_color = color;
        anim_dir   = dir;
        anim_en    = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (busy !== 1'b1 && n < TICK_DIV + 10);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL tick_start_timeout: busy=%b after %0d cycles, required 1", busy, n);
        end
        n = 0;
        while (busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL tick_end_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
        #1 anim_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; host_req = 1'b0; host_adr = '0; host_dat = '0;
        anim_en = 1'b0; anim_dir = 1'b0; anim_color = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ram_we !== 1'b0)    begin failures++; $display("FAIL reset_we: got %b, required 0", ram_we); end
        checks++; if (ram_adr !== 11'd0)  begin failures++; $display("FAIL reset_adr: got %h, required 000", ram_adr); end
        checks++; if (ram_dat !== 8'd0)   begin failures++; $display("FAIL reset_dat: got %h, required 00", ram_dat); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (pos !== 6'd0)       begin failures++; $display("FAIL reset_pos: got %0d, required 0", pos); end
        checks++; if (host_gnt !== 1'b0)  begin failures++; $display("FAIL reset_gnt: got %b, required 0", host_gnt); end
        #1 reset = 1'b0;
        m_pos = 0;
        clear_logs();
    endtask

    task automatic test_first_tick();
        int n;
        model_burst(32'h11223344, 1'b0);
        anim_color = 32'h11223344; anim_dir = 1'b0; anim_en = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (busy !== 1'b1 && n < 40);
        checks++;
        if (n !== TICK_DIV + 1) begin
            failures++;
            $display("FAIL first_tick_latency: burst began at cycle %0d, required %0d", n, TICK_DIV + 1);
        end
        n = 0;
        while (busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
        #1 anim_en = 1'b0;
        checks++;
        if (burst_q.size() != exp_q.size()) begin
            failures++; $display("FAIL first_tick_count: got %0d writes, required %0d", burst_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (burst_q[i].adr !== exp_q[i].adr || burst_q[i].dat !== exp_q[i].dat) begin
                failures++;
                $display("FAIL first_tick_wr%0d: got adr=%h dat=%h, required adr=%h dat=%h", i, burst_q[i].adr, burst_q[i].dat, exp_q[i].adr, exp_q[i].dat);
            end
        end
        checks++; if (pos !== 6'd1) begin failures++; $display("FAIL first_tick_pos: got %0d, required 1", pos); end
        clear_logs();
    endtask

    task automatic test_wrap();
        logic [31:0] color;
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
        m_pos = 0;
        for (int d = 1; d >= 0; d--) begin
            color = $urandom;
            clear_logs();
            model_burst(color, d[0]);
            run_one_tick(color, d[0]);
            checks++;
            if (burst_q.size() != exp_q.size()) begin
                failures++; $display("FAIL wrap_dir%0d_count: got %0d writes, required %0d", d, burst_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                checks++;
                if (burst_q[i].adr !== exp_q[i].adr || burst_q[i].dat !== exp_q[i].dat) begin
                    failures++;
                    $display("FAIL wrap_dir%0d_wr%0d: got adr=%h dat=%h, required adr=%h dat=%h", d, i, burst_q[i].adr, burst_q[i].dat, exp_q[i].adr, exp_q[i].dat);
                end
            end
            checks++;
            if (pos !== (d == 1 ? 6'd34 : 6'd0)) begin
                failures++; $display("FAIL wrap_dir%0d_pos: got %0d, required %0d", d, pos, (d == 1 ? 34 : 0));
            end
        end
        clear_logs();
    endtask

    task automatic test_host_during_set();
        int n;
        logic [31:0] color;
        color = $urandom;
        clear_logs();
        model_burst(color, 1'b0);
        anim_color = color; anim_dir = 1'b0; anim_en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (busy !== 1'b1 && n < TICK_DIV + 10);
        repeat (5) @(negedge clk);
        #1 host_req = 1'b1; host_adr = 11'h123; host_dat = 8'hA5;
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (host_gnt !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL host_wait_set%0d: gnt=%b busy=%b, required gnt=0 busy=1", k, host_gnt, busy);
            end
        end
        @(negedge clk);
        checks++; if (host_gnt !== 1'b1) begin failures++; $display("FAIL host_after_burst_gnt: got %b, required 1", host_gnt); end
        checks++; if (ram_we !== 1'b1)   begin failures++; $display("FAIL host_after_burst_we: got %b, required 1", ram_we); end
        checks++; if (ram_adr !== 11'h123) begin failures++; $display("FAIL host_after_burst_adr: got %h, required 123", ram_adr); end
        checks++; if (ram_dat !== 8'hA5) begin failures++; $display("FAIL host_after_burst_dat: got %h, required a5", ram_dat); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL host_after_burst_busy: got %b, required 0", busy); end
        #1 host_req = 1'b0; anim_en = 1'b0;
        @(negedge clk);
        checks++;
        if (burst_q.size() != exp_q.size()) begin
            failures++; $display("FAIL host_set_burst_count: got %0d writes, required %0d", burst_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (burst_q[i].adr !== exp_q[i].adr || burst_q[i].dat !== exp_q[i].dat) begin
                failures++;
                $display("FAIL host_set_wr%0d: got adr=%h dat=%h, required adr=%h dat=%h", i, burst_q[i].adr, burst_q[i].dat, exp_q[i].adr, exp_q[i].dat);
            end
        end
        checks++; if (host_q.size() != 1) begin failures++; $display("FAIL host_set_grants: got %0d host writes, required 1", host_q.size()); end
        clear_logs();
    endtask

    task automatic test_host_and_tick();
        wr_t sent_q[$];
        int n, bursts;
        logic prev_gnt, prev_busy, cur_gnt, cur_busy;
        logic [31:0] color;
        logic dir;
        color = $urandom; dir = 1'($urandom_range(0, 1));
        clear_logs();
        model_burst(color, dir);
        anim_color = color; anim_dir = dir; anim_en = 1'b1;
        host_req = 1'b1; host_adr = 11'($urandom_range(0, 2047)); host_dat = 8'($urandom_range(0, 255));
        n = 0; bursts = 0; prev_gnt = 1'b0; prev_busy = 1'b0;
        while ((host_req === 1'b1 || busy === 1'b1) && n < 200) begin
            @(negedge clk); n++;
            cur_gnt = host_gnt; cur_busy = busy;
            if (cur_busy === 1'b1 && prev_busy === 1'b0) begin
                bursts++;
                checks++;
                if (prev_gnt !== 1'b1) begin failures++; $display("FAIL stream_host_before_clr: gnt before burst=%b, required 1", prev_gnt); end
            end
            if (cur_busy === 1'b0 && prev_busy === 1'b1 && host_req === 1'b1) begin
                checks++;
                if (cur_gnt !== 1'b1) begin failures++; $display("FAIL stream_gnt_after_burst: got %b, required 1", cur_gnt); end
            end
            if (cur_gnt === 1'b1) sent_q.push_back('{host_adr, host_dat});
            #1;
            if (cur_busy === 1'b0 && prev_busy === 1'b1) anim_en = 1'b0;
            if (cur_gnt === 1'b1) begin
                if (sent_q.size() < 20) begin
                    host_adr = 11'($urandom_range(0, 2047)); host_dat = 8'($urandom_range(0, 255));
                end else host_req = 1'b0;
            end
            prev_gnt = cur_gnt; prev_busy = cur_busy;
        end
        host_req = 1'b0; anim_en = 1'b0;
        checks++; if (n >= 200) begin failures++; $display("FAIL stream_timeout: ran %0d cycles, required < 200", n); end
        checks++; if (bursts != 1) begin failures++; $display("FAIL stream_bursts: got %0d bursts, required 1", bursts); end
        checks++;
        if (host_q.size() != sent_q.size()) begin
            failures++; $display("FAIL stream_host_count: got %0d host writes, required %0d", host_q.size(), sent_q.size());
        end else foreach (sent_q[i]) begin
            checks++;
            if (host_q[i].adr !== sent_q[i].adr || host_q[i].dat !== sent_q[i].dat) begin
                failures++;
                $display("FAIL stream_host_wr%0d: got adr=%h dat=%h, required adr=%h dat=%h", i, host_q[i].adr, host_q[i].dat, sent_q[i].adr, sent_q[i].dat);
            end
        end
        checks++;
        if (burst_q.size() != exp_q.size()) begin
            failures++; $display("FAIL stream_burst_count: got %0d writes, required %0d", burst_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (burst_q[i].adr !== exp_q[i].adr || burst_q[i].dat !== exp_q[i].dat) begin
                failures++;
                $display("FAIL stream_burst_wr%0d: got adr=%h dat=%h, required adr=%h dat=%h", i, burst_q[i].adr, burst_q[i].dat, exp_q[i].adr, exp_q[i].dat);
            end
        end
        clear_logs();
    endtask

    task automatic test_reset_mid_burst();
        int n;
        run_one_tick($urandom, 1'b0);
        m_pos = (m_pos + 1) % N_LEDS;
        if (m_pos == 0) begin
            run_one_tick($urandom, 1'b0);
            m_pos = 1;
        end
        anim_color = $urandom; anim_dir = 1'b0; anim_en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (busy !== 1'b1 && n < TICK_DIV + 10);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1; anim_en = 1'b0;
        @(negedge clk);
        checks++; if (ram_we !== 1'b0)   begin failures++; $display("FAIL abort_we: got %b, required 0", ram_we); end
        checks++; if (pos !== 6'd0)      begin failures++; $display("FAIL abort_pos: got %0d, required 0", pos); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL abort_busy: got %b, required 0", busy); end
        checks++; if (ram_adr !== 11'd0 || ram_dat !== 8'd0 || host_gnt !== 1'b0) begin
            failures++; $display("FAIL abort_outputs: adr=%h dat=%h gnt=%b, required 000 00 0", ram_adr, ram_dat, host_gnt);
        end
        #1 reset = 1'b0;
        m_pos = 0;
        clear_logs();
        repeat (3 * TICK_DIV) @(negedge clk);
        checks++;
        if (burst_q.size() + host_q.size() != 0) begin
            failures++; $display("FAIL abort_quiet: got %0d writes, required 0", burst_q.size() + host_q.size());
        end
        clear_logs();
    endtask

    task automatic test_trail();
        logic [7:0] exp_clr [4];
`ifdef EVERLOOP_SEQ_TRAIL_EN
        exp_clr = '{8'h08, 8'h10, 8'h20, 8'h40};
`else
        exp_clr = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
        clear_logs();
        model_burst(32'h80402010, 1'b0);
        run_one_tick(32'h80402010, 1'b0);
        checks++;
        if (burst_q.size() < 8) begin
            failures++; $display("FAIL trail_count: got %0d writes, required 8", burst_q.size());
        end else for (int k = 0; k < 4; k++) begin
            checks++;
            if (burst_q[k].dat !== exp_clr[k]) begin
                failures++; $display("FAIL trail_clr%0d: got %h, required %h", k, burst_q[k].dat, exp_clr[k]);
            end
        end
        clear_logs();
    endtask

    task automatic test_random();
        logic [31:0] color;
        logic dir;
        int n;
        for (int it = 0; it < 6; it++) begin
            color = $urandom; dir = 1'($urandom_range(0, 1));
            clear_logs();
            model_burst(color, dir);
            run_one_tick(color, dir);
            checks++;
            if (burst_q.size() != exp_q.size()) begin
                failures++; $display("FAIL rand%0d_count: got %0d writes, required %0d", it, burst_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                checks++;
                if (burst_q[i].adr !== exp_q[i].adr || burst_q[i].dat !== exp_q[i].dat) begin
                    failures++;
                    $display("FAIL rand%0d_wr%0d: got adr=%h dat=%h, required adr=%h dat=%h", it, i, burst_q[i].adr, burst_q[i].dat, exp_q[i].adr, exp_q[i].dat);
                end
            end
            checks++;
            if (pos !== 6'(m_pos)) begin failures++; $display("FAIL rand%0d_pos: got %0d, required %0d", it, pos, m_pos); end
            host_req = 1'b1; host_adr = 11'($urandom_range(0, 2047)); host_dat = 8'($urandom_range(0, 255));
            n = 0;
            do begin @(negedge clk); n++; end while (host_gnt !== 1'b1 && n < 10);
            checks++;
            if (host_gnt !== 1'b1 || ram_adr !== host_adr || ram_dat !== host_dat) begin
                failures++;
                $display("FAIL rand%0d_host: gnt=%b adr=%h dat=%h, required gnt=1 adr=%h dat=%h", it, host_gnt, ram_adr, ram_dat, host_adr, host_dat);
            end
            #1 host_req = 1'b0;
        end
        clear_logs();
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_wrap();
        test_host_during_set();
        test_host_and_tick();
        test_reset_mid_burst();
        test_trail();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
